uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame.
REQ-002 SHALL have parameter PRESCALE_W, default 6, meaning the width of Prescale and edge_cnt.
REQ-003 SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-005 SHALL have port RX_IN  in  1  serial line, idle high.
REQ-006 SHALL have port PAR_EN  in  1  parity bit present in the frame.
REQ-007 SHALL have port Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
REQ-008 SHALL have ports par_err, strt_glitch, stp_err  in  1 each  results from the parity, start and stop checkers.
REQ-009 SHALL have port edge_cnt  out  PRESCALE_W  edge count within the current bit.
REQ-010 SHALL have port bit_cnt  out  4  bit index within the frame (0 = start bit).
REQ-011 SHALL have ports edge_cnt_en, dat_samp_en, deser_en, par_chk_en, strt_chk_en, stp_chk_en  out  1 each  datapath enables.
REQ-012 SHALL have ports data_valid, par_error, frame_error  out  1 each  one-cycle frame result pulses.

Function
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY, STOP and ERR_CHK, with state and counters registered.
REQ-014 SHALL decode all outputs combinationally from the registered state and counters (Moore).
REQ-015 SHALL latch Prescale into pscale_q on the IDLE->START or ERR_CHK->START transition, treating any value other than 8, 16 or 32 as 8; mid-frame changes of Prescale SHALL be ignored.
REQ-016 SHALL, in IDLE, hold edge_cnt and bit_cnt at 0 and all enables at 0, and transition to START on the next edge after RX_IN is sampled as 0.
REQ-017 SHALL, in START through STOP, increment edge_cnt every cycle from 0 to pscale_q-1 and wrap to 0; on that wrap, bit_cnt SHALL increment.
REQ-018 SHALL assert edge_cnt_en and dat_samp_en in START, DATA, PARITY and STOP, and deassert both in IDLE and ERR_CHK.
REQ-019 SHALL assert strt_chk_en throughout START; if strt_glitch is 1 when edge_cnt == pscale_q-1, the next state SHALL be IDLE with no result pulses, otherwise DATA.
REQ-020 SHALL, in DATA, pulse deser_en for exactly one cycle per bit when edge_cnt == pscale_q/2+2, giving DATA_WIDTH pulses per frame.
REQ-021 SHALL leave DATA at the end of bit_cnt == DATA_WIDTH, going to PARITY if PAR_EN is 1, otherwise STOP; PAR_EN SHALL be sampled at that transition.
REQ-022 SHALL assert par_chk_en throughout PARITY and latch par_err into par_err_q at edge_cnt == pscale_q-1.
REQ-023 SHALL assert stp_chk_en throughout STOP, latch stp_err into stp_err_q at edge_cnt == pscale_q-1, then enter ERR_CHK.
REQ-024 SHALL make ERR_CHK last exactly one cycle with the following outputs:
- data_valid = !(par_err_q | stp_err_q)
- par_error = par_err_q
- frame_error = stp_err_q
REQ-025 SHALL leave ERR_CHK for START if RX_IN == 0 (back-to-back frame; edge_cnt and bit_cnt restart at 0), otherwise for IDLE.
REQ-026 SHALL clear par_err_q and stp_err_q on every entry to START.
REQ-027 SHALL time the frame so that, with RX_IN first sampled low in cycle t, ERR_CHK occurs in cycle t+1+(DATA_WIDTH+2+PAR_EN)*pscale_q.
REQ-028 SHALL hold all result pulses at 0 in every state other than ERR_CHK.

Reset
REQ-029 SHALL, while RST is 1 at a rising CLK edge (including mid-frame), force IDLE, clear edge_cnt, bit_cnt, pscale_q, par_err_q and stp_err_q to 0, and drive every output to 0 from the following cycle.
REQ-030 SHALL, after RST deasserts, start no frame until RX_IN is sampled as 0.

Verification
REQ-031 SHALL be verified with a good frame (Prescale=8, PAR_EN=1, no checker errors): ERR_CHK 89 cycles after the first low sample, data_valid=1 for one cycle, and exactly 8 deser_en pulses, each at edge_cnt=6.
REQ-032 SHALL be verified with a start glitch (Prescale=16, strt_glitch=1 at edge 15 of START): return to IDLE, no deser_en and no result pulses.
REQ-033 SHALL be verified with a parity error (Prescale=32, PAR_EN=1, par_err=1 at edge 31 of PARITY): par_error=1 and data_valid=0 in ERR_CHK.
REQ-034 SHALL be verified with back-to-back frames (PAR_EN=0, stp_err=1 on frame 1, RX_IN=0 in ERR_CHK): frame_error on frame 1, the next cycle is START with counters 0, and frame 2 gives data_valid=1.
REQ-035 SHALL be verified with illegal and changing Prescale (Prescale=12 latched, changed to 16 mid-frame): frame timed with pscale_q=8 throughout.
REQ-036 SHALL be verified with reset mid-DATA (bit_cnt=4): IDLE and all outputs 0 in the next cycle, then a correct frame after release.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: walks a frame bit by bit at the oversampling rate and
// issues the datapath enables and the one-cycle frame result pulses.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  par_err,
    input  logic                  strt_glitch,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  edge_cnt_en,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  strt_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  par_error,
    output logic                  frame_error
);

    // state   | meaning
    // IDLE    | line idle, waiting for a low sample
    // START   | start bit, glitch check on its last edge
    // DATA    | data bits 1..DATA_WIDTH, one deserialiser strobe per bit
    // PARITY  | parity bit, parity result latched on its last edge
    // STOP    | stop bit, stop result latched on its last edge
    // ERR_CHK | single cycle issuing the frame result pulses
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        ERR_CHK
    } state_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] pscale_q, pscale_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic [PRESCALE_W-1:0] pscale_sel;
    logic [PRESCALE_W-1:0] samp_edge;
    logic                  last_edge;
    logic                  counting;

    // Unsupported ratios fall back to the slowest-oversampling legal setting.
    assign pscale_sel = (Prescale == PRESCALE_W'(16) || Prescale == PRESCALE_W'(32))
                        ? Prescale : PRESCALE_W'(8);
    assign last_edge  = (edge_q == pscale_q - PRESCALE_W'(1));
    assign samp_edge  = (pscale_q >> 1) + PRESCALE_W'(2);
    assign counting   = (state_q == START) || (state_q == DATA) ||
                        (state_q == PARITY) || (state_q == STOP);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            pscale_q  <= '0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            pscale_q  <= pscale_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        pscale_d  = pscale_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;

        if (counting) begin
            if (last_edge) begin
                edge_d = '0;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!RX_IN) begin
                    state_d   = START;
                    pscale_d  = pscale_sel;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (last_edge) begin
                    if (strt_glitch) begin
                        state_d = IDLE;
                        edge_d  = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_edge && bit_q == 4'(DATA_WIDTH)) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    par_err_d = par_err;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    stp_err_d = stp_err;
                    state_d   = ERR_CHK;
                    edge_d    = '0;
                    bit_d     = '0;
                end
            end
            ERR_CHK: begin
                edge_d = '0;
                bit_d  = '0;
                // A low line here is the start bit of the next frame.
                if (!RX_IN) begin
                    state_d   = START;
                    pscale_d  = pscale_sel;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_comb begin
        edge_cnt    = edge_q;
        bit_cnt     = bit_q;
        edge_cnt_en = counting;
        dat_samp_en = counting;
        strt_chk_en = (state_q == START);
        deser_en    = (state_q == DATA) && (edge_q == samp_edge);
        par_chk_en  = (state_q == PARITY);
        stp_chk_en  = (state_q == STOP);
        data_valid  = (state_q == ERR_CHK) && !(par_err_q || stp_err_q);
        par_error   = (state_q == ERR_CHK) && par_err_q;
        frame_error = (state_q == ERR_CHK) && stp_err_q;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: frames are timed from arithmetic on the
// effective prescale and bit count, with random noise on every ignored input.
module tb_uart_rx_fsm;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST, RX_IN, PAR_EN;
    logic [PW-1:0] Prescale;
    logic          par_err, strt_glitch, stp_err;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          edge_cnt_en, dat_samp_en, deser_en, par_chk_en, strt_chk_en, stp_chk_en;
    logic          data_valid, par_error, frame_error;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .par_err(par_err), .strt_glitch(strt_glitch), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .edge_cnt_en(edge_cnt_en), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
        .par_chk_en(par_chk_en), .strt_chk_en(strt_chk_en), .stp_chk_en(stp_chk_en),
        .data_valid(data_valid), .par_error(par_error), .frame_error(frame_error)
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   trace_err, deser_n, deser_bad, res_k, n_res;
    logic dv_o, pe_o, fe_o;

    function automatic int eff_ps(input int ps);
        return (ps == 8 || ps == 16 || ps == 32) ? ps : 8;
    endfunction

    function automatic int pick_ps();
        case ($urandom % 5)
            0: return 8;
            1: return 16;
            2: return 32;
            3: return 12;
            default: return 0;
        endcase
    endfunction

    function automatic logic any_out();
        return |{edge_cnt, bit_cnt, edge_cnt_en, dat_samp_en, deser_en, par_chk_en,
                 strt_chk_en, stp_chk_en, data_valid, par_error, frame_error};
    endfunction

    // Drives one frame whose first low sample is the current cycle and records
    // what the DUT did; expected per-cycle behaviour comes from frame position.
    task automatic drive_frame(input int ps, input bit par, input bit glitch,
                               input bit perr, input bit serr, input bit b2b,
                               input bit started, input int ps_next,
                               input int mid_ps, input int rst_at);
        int pe, nbits, len, pos, eb, ee;
        bit inf, st_e, da_e, pa_e, sp_e, de_e, bad;
        pe    = eff_ps(ps);
        nbits = DW + 2 + int'(par);
        len   = glitch ? pe + 1 : 1 + nbits * pe;
        trace_err = 0; deser_n = 0; deser_bad = 0; res_k = 0; n_res = 0;
        dv_o = 1'b0; pe_o = 1'b0; fe_o = 1'b0;
        if (!started) begin
            RX_IN    = 1'b0;
            Prescale = PW'(ps);
        end
        PAR_EN = par;
        for (int k = 1; k <= len; k++) begin
            @(negedge CLK);
            pos  = k - 1;
            inf  = (k < len);
            eb   = pos / pe;
            ee   = pos % pe;
            st_e = inf && eb == 0;
            da_e = inf && eb >= 1 && eb <= DW;
            pa_e = inf && par && eb == DW + 1;
            sp_e = inf && eb == DW + 1 + int'(par);
            de_e = da_e && ee == pe / 2 + 2;
            bad  = (edge_cnt_en !== inf) || (dat_samp_en !== inf) || (strt_chk_en !== st_e) ||
                   (par_chk_en !== pa_e) || (stp_chk_en !== sp_e) || (deser_en !== de_e);
            if (inf && (edge_cnt !== PW'(ee) || bit_cnt !== 4'(eb))) bad = 1'b1;
            if (glitch && !inf && (edge_cnt !== '0 || bit_cnt !== '0)) bad = 1'b1;
            if (bad) trace_err++;
            if (deser_en === 1'b1) begin
                deser_n++;
                if (edge_cnt !== PW'(pe / 2 + 2)) deser_bad++;
            end
            if (data_valid === 1'b1 || par_error === 1'b1 || frame_error === 1'b1) begin
                n_res++;
                if (res_k == 0) begin
                    res_k = k; dv_o = data_valid; pe_o = par_error; fe_o = frame_error;
                end
            end
            if (k == rst_at) begin
                RST   = 1'b1;
                RX_IN = 1'b0;
                return;
            end
            RX_IN       = 1'($urandom);
            strt_glitch = (k == pe) ? glitch : 1'($urandom);
            par_err     = (k == (DW + 2) * pe) ? perr : 1'($urandom);
            stp_err     = (k == nbits * pe) ? serr : 1'($urandom);
            PAR_EN      = (k == (DW + 1) * pe) ? par : 1'($urandom);
            Prescale    = PW'((mid_ps != 0) ? mid_ps : pick_ps());
            if (k == len) begin
                RX_IN    = b2b ? 1'b0 : 1'b1;
                Prescale = PW'(ps_next);
            end
        end
    endtask

    task automatic idle_cycles(input int n, output int errs);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            RX_IN = 1'b1;
            @(negedge CLK);
            if (any_out() !== 1'b0) errs++;
            par_err = 1'($urandom); stp_err = 1'($urandom); strt_glitch = 1'($urandom);
            PAR_EN = 1'($urandom); Prescale = PW'(pick_ps());
        end
    endtask

    task automatic test_reset();
        int errs;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            RX_IN = 1'($urandom); PAR_EN = 1'($urandom); Prescale = PW'(pick_ps());
            @(negedge CLK);
        end
        n_checks++;
        if (any_out() !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
        end
        RST = 1'b0;
        idle_cycles(6, errs);
        n_checks++;
        if (errs !== 0) begin
            n_fail++; $display("FAIL reset_idle_hold: got %0d active cycles, expected 0", errs);
        end
    endtask

    task automatic test_good_frame();
        int errs;
        drive_frame(8, 1, 0, 0, 0, 0, 0, 8, 0, 0);
        n_checks++; if (res_k !== 89) begin n_fail++; $display("FAIL good_errchk_cycle: got %0d expected 89", res_k); end
        n_checks++; if (dv_o !== 1'b1 || pe_o !== 1'b0 || fe_o !== 1'b0) begin
            n_fail++; $display("FAIL good_results: got dv=%0b pe=%0b fe=%0b expected 1 0 0", dv_o, pe_o, fe_o); end
        n_checks++; if (n_res !== 1) begin n_fail++; $display("FAIL good_pulse_len: got %0d expected 1", n_res); end
        n_checks++; if (deser_n !== 8 || deser_bad !== 0) begin
            n_fail++; $display("FAIL good_deser: got %0d pulses %0d off-edge expected 8 0", deser_n, deser_bad); end
        n_checks++; if (trace_err !== 0) begin n_fail++; $display("FAIL good_trace: got %0d bad cycles expected 0", trace_err); end
        idle_cycles(2, errs);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL good_return_idle: got %0d expected 0", errs); end
    endtask

    task automatic test_start_glitch();
        int errs;
        drive_frame(16, 1, 1, 0, 0, 0, 0, 16, 0, 0);
        n_checks++; if (n_res !== 0 || deser_n !== 0) begin
            n_fail++; $display("FAIL glitch_no_pulses: got res=%0d deser=%0d expected 0 0", n_res, deser_n); end
        n_checks++; if (trace_err !== 0) begin n_fail++; $display("FAIL glitch_trace: got %0d expected 0", trace_err); end
        idle_cycles(3, errs);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL glitch_idle: got %0d expected 0", errs); end
    endtask

    task automatic test_parity_error();
        int errs;
        drive_frame(32, 1, 0, 1, 0, 0, 0, 8, 0, 0);
        n_checks++; if (res_k !== 1 + 11 * 32) begin n_fail++; $display("FAIL par_errchk_cycle: got %0d expected %0d", res_k, 1 + 11 * 32); end
        n_checks++; if (pe_o !== 1'b1 || dv_o !== 1'b0 || fe_o !== 1'b0) begin
            n_fail++; $display("FAIL par_results: got dv=%0b pe=%0b fe=%0b expected 0 1 0", dv_o, pe_o, fe_o); end
        n_checks++; if (trace_err !== 0) begin n_fail++; $display("FAIL par_trace: got %0d expected 0", trace_err); end
        idle_cycles(2, errs);
    endtask

    task automatic test_back_to_back();
        int errs;
        drive_frame(16, 0, 0, 0, 1, 1, 0, 8, 0, 0);
        n_checks++; if (fe_o !== 1'b1 || dv_o !== 1'b0 || res_k !== 1 + 10 * 16) begin
            n_fail++; $display("FAIL b2b_frame1: got fe=%0b dv=%0b at %0d expected 1 0 at %0d", fe_o, dv_o, res_k, 1 + 10 * 16); end
        drive_frame(8, 0, 0, 0, 0, 0, 1, 8, 0, 0);
        n_checks++; if (trace_err !== 0) begin n_fail++; $display("FAIL b2b_frame2_trace: got %0d expected 0", trace_err); end
        n_checks++; if (dv_o !== 1'b1 || fe_o !== 1'b0 || res_k !== 1 + 10 * 8) begin
            n_fail++; $display("FAIL b2b_frame2: got dv=%0b fe=%0b at %0d expected 1 0 at %0d", dv_o, fe_o, res_k, 1 + 10 * 8); end
        idle_cycles(2, errs);
    endtask

    task automatic test_prescale();
        int errs;
        drive_frame(12, 1, 0, 0, 0, 0, 0, 8, 16, 0);
        n_checks++; if (res_k !== 89 || trace_err !== 0) begin
            n_fail++; $display("FAIL prescale_fallback: got errchk %0d trace %0d expected 89 0", res_k, trace_err); end
        n_checks++; if (deser_n !== 8 || deser_bad !== 0) begin
            n_fail++; $display("FAIL prescale_deser: got %0d/%0d expected 8/0", deser_n, deser_bad); end
        idle_cycles(2, errs);
    endtask

    task automatic test_reset_mid_data();
        int errs;
        drive_frame(8, 1, 0, 0, 0, 0, 0, 8, 0, 1 + 4 * 8 + 2);
        @(negedge CLK);
        n_checks++; if (any_out() !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got edge=%0d bit=%0d en=%0b expected all 0", edge_cnt, bit_cnt, edge_cnt_en); end
        RST = 1'b0;
        idle_cycles(5, errs);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL rst_mid_no_start: got %0d expected 0", errs); end
        drive_frame(16, 0, 0, 0, 0, 0, 0, 8, 0, 0);
        n_checks++; if (res_k !== 1 + 10 * 16 || dv_o !== 1'b1 || trace_err !== 0) begin
            n_fail++; $display("FAIL rst_mid_recovery: got errchk %0d dv=%0b trace %0d expected %0d 1 0", res_k, dv_o, trace_err, 1 + 10 * 16); end
        idle_cycles(2, errs);
    endtask

    task automatic test_random();
        int ps, ps_next, pe, len, errs;
        bit par, gl, perr, serr, b2b, started;
        started = 0;
        ps = pick_ps();
        for (int i = 0; i < 8; i++) begin
            par  = 1'($urandom); gl = ($urandom % 4) == 0;
            perr = 1'($urandom); serr = 1'($urandom);
            b2b  = gl ? 1'b0 : 1'($urandom);
            ps_next = pick_ps();
            pe  = eff_ps(ps);
            len = 1 + (DW + 2 + int'(par)) * pe;
            drive_frame(ps, par, gl, perr, serr, b2b, started, ps_next, 0, 0);
            n_checks++; if (trace_err !== 0) begin n_fail++; $display("FAIL rand%0d_trace: got %0d expected 0", i, trace_err); end
            n_checks++;
            if (gl) begin
                if (n_res !== 0 || deser_n !== 0) begin
                    n_fail++; $display("FAIL rand%0d_glitch: got res=%0d deser=%0d expected 0 0", i, n_res, deser_n); end
            end else if (res_k !== len || n_res !== 1 || deser_n !== DW ||
                         dv_o !== !((par && perr) || serr) || pe_o !== (par && perr) || fe_o !== serr) begin
                n_fail++;
                $display("FAIL rand%0d_frame: got k=%0d dv=%0b pe=%0b fe=%0b deser=%0d expected k=%0d dv=%0b pe=%0b fe=%0b deser=%0d",
                         i, res_k, dv_o, pe_o, fe_o, deser_n, len, !((par && perr) || serr), par && perr, serr, DW);
            end
            if (!b2b) idle_cycles(1 + int'($urandom % 3), errs);
            started = b2b;
            ps = ps_next;
        end
    endtask

    initial begin
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = PW'(8);
        par_err = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0;
        test_reset();
        test_good_frame();
        test_start_glitch();
        test_parity_error();
        test_back_to_back();
        test_prescale();
        test_reset_mid_data();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
